regfile_write_bank: RTL and testbench
=====================================

Name: regfile_write_bank

Overview:
- Storage and write-port stage of the 32x64 ARM register file.
- Holds the 32 architectural 64-bit registers.
- Takes one pipelined write per cycle through a one-entry staging register.
- Drives all 32 register values in parallel to the downstream 64-bit 32:1 read muxes; X31 (XZR) always reads zero.

Parameters:
- NREGS, 32, number of architectural registers (fixed; only 32 supported).
- WIDTH, 64, register width in bits.
- ZERO_REG, 31, index hardwired to zero; writes to it are dropped.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request present this cycle.
- wr_ready  out  1  bank can accept a request this cycle.
- wr_addr  in  5  destination register index.
- wr_data  in  64  write data.
- hold  in  1  freezes commit of the staged write (pipeline stall).
- stg_valid  out  1  staging register holds an uncommitted write.
- stg_addr  out  5  staged destination index (for hazard/forward logic).
- stg_data  out  64  staged write data.
- q  out  32x64  all register contents, packed [31:0][63:0], index i = register Xi, to the read muxes.

Behaviour:
- Reset is asynchronous on reset_n low, regardless of clk:
  - all 32 registers = 0.
  - stg_valid = 0, stg_addr = 0, stg_data = 0.
  - wr_ready = 1.
  - q = all zeros.
- Release is synchronous to the next rising clk.
- Two-stage write path:
  - Cycle N, accept: wr_valid && wr_ready → staging loads {wr_addr, wr_data}; stg_valid = 1 at edge N.
  - Cycle N+1, commit: stg_valid && !hold → register[stg_addr] = stg_data at edge N+1, so q[stg_addr] shows the new value after edge N+1. Total write latency = 2 edges.
- wr_ready = !stg_valid || !hold (combinational):
  - A commit and a new accept may occur on the same edge; the staging register reloads and one write per cycle is sustained.
  - While hold = 1 with a full stage: wr_ready = 0, the stage holds its contents, and wr_valid is ignored (requester must keep the request stable).
- Drain: after a commit with no new accept, stg_valid = 0.
- ZERO_REG handling:
  - An accepted request with wr_addr = 31 is still staged (stg_valid = 1) to keep handshake timing uniform.
  - Its commit does not modify storage.
  - q[31] is always 0.
- Back-to-back writes to the same address: commit in order; the last value wins.
- Reset mid-operation: the staged write is discarded; no partial commit.
- Only one register changes per edge. All other registers hold.
- Write decode is built from 5:32 decoders of ≤4-input gates to match the read mux construction.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: q is write-through. When stg_valid = 1 and stg_addr != 31, q[stg_addr] = stg_data combinationally in the same cycle the write is staged. Reads therefore see the new value one edge earlier; committed storage timing is unchanged.
- Undefined: q reflects committed storage only, as above.

Test Plan:
- Reset: write X5 = 0xDEAD_BEEF_0000_0001, then pull reset_n low mid-cycle (between edges) → q all zero immediately; stg_valid = 0; wr_ready = 1.
- Single write: wr_valid = 1, wr_addr = 3, wr_data = 0x0123_4567_89AB_CDEF at edge 1 → stg_valid = 1 after edge 1; q[3] = 0x0123_4567_89AB_CDEF after edge 2, or after edge 1 with bypass; other registers 0.
- Streaming: writes to X0..X30 on consecutive cycles with data = index*0x1111 → wr_ready stays 1; after 32 edges q[i] = i*0x1111 for all i; q[31] = 0.
- Zero register: write X31 = 0xFFFF_FFFF_FFFF_FFFF → stg_valid pulses 1 for one cycle; q[31] remains 0 throughout, with or without bypass.
- Hold: stage X7 = 0xAA, assert hold for 3 cycles with wr_valid = 1, wr_addr = 8 → wr_ready = 0 for 3 cycles; q[7] unchanged (non-bypass); release hold → q[7] = 0xAA next edge and X8 accepted on the same edge.
- Same-address: consecutive writes X9 = 1, then X9 = 2 → q[9] = 1 after edge 2, q[9] = 2 after edge 3.

Source files
------------

// File: rtl/regfile_write_bank.sv
// regfile_write_bank: storage and write-port stage of the 32x64 register file.
// Holds the architectural registers and accepts one pipelined write per cycle
// through a one-entry staging register. It drives every register value in
// parallel to the downstream 32:1 read muxes. X31 (XZR) always reads zero.
//
// Optional feature macro: REGFILE_WRITE_BYPASS_EN
//   defined   : q is write-through. A staged write appears on q in the same
//               cycle it is staged. Committed storage timing does not change.
//   undefined : q reflects committed storage only.
module regfile_write_bank #(
  parameter int NREGS    = 32,
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [4:0]                   wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         hold,
  output logic                         stg_valid,
  output logic [4:0]                   stg_addr,
  output logic [WIDTH-1:0]             stg_data,
  output logic [NREGS-1:0][WIDTH-1:0]  q
);

  // Low predecode of the 5:32 decoder. The enable is folded into this
  // stage, so each output is a 3-input AND.
  function automatic logic [3:0] predec_lo(input logic en, input logic [1:0] a);
    logic [3:0] d;
    d[0] = en & ~a[1] & ~a[0];
    d[1] = en & ~a[1] &  a[0];
    d[2] = en &  a[1] & ~a[0];
    d[3] = en &  a[1] &  a[0];
    return d;
  endfunction

  // High predecode of the 5:32 decoder. Each output is a 3-input AND.
  function automatic logic [7:0] predec_hi(input logic [2:0] a);
    logic [7:0] d;
    d[0] = ~a[2] & ~a[1] & ~a[0];
    d[1] = ~a[2] & ~a[1] &  a[0];
    d[2] = ~a[2] &  a[1] & ~a[0];
    d[3] = ~a[2] &  a[1] &  a[0];
    d[4] =  a[2] & ~a[1] & ~a[0];
    d[5] =  a[2] & ~a[1] &  a[0];
    d[6] =  a[2] &  a[1] & ~a[0];
    d[7] =  a[2] &  a[1] &  a[0];
    return d;
  endfunction

  // Staging register
  logic              r_stg_valid;
  logic [4:0]        r_stg_addr;
  logic [WIDTH-1:0]  r_stg_data;

  // Handshake and commit control
  logic              w_ready;
  logic              w_commit;

  // Predecoded commit select (final 2-input AND is per register)
  logic [3:0]        w_wr_lo;
  logic [7:0]        w_wr_hi;

  // The stage can take a new request when it is empty, or when its content
  // commits on this same edge. This sustains one write per cycle.
  assign w_ready  = ~r_stg_valid | ~hold;
  assign w_commit = r_stg_valid & ~hold;

  assign w_wr_lo  = predec_lo(w_commit, r_stg_addr[1:0]);
  assign w_wr_hi  = predec_hi(r_stg_addr[4:2]);

  assign wr_ready  = w_ready;
  assign stg_valid = r_stg_valid;
  assign stg_addr  = r_stg_addr;
  assign stg_data  = r_stg_data;

  // Staging register: load on accept, drain when committing with no new
  // request, freeze while held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stg_valid <= 1'b0;
      r_stg_addr  <= '0;
      r_stg_data  <= '0;
    end else if (w_ready) begin
      r_stg_valid <= wr_valid;
      if (wr_valid) begin
        r_stg_addr <= wr_addr;
        r_stg_data <= wr_data;
      end
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  // The write-through select reuses the same decoder structure. It is
  // enabled by a valid stage alone, and hold has no effect on it.
  logic [3:0]        w_byp_lo;
  logic [7:0]        w_byp_hi;

  assign w_byp_lo = predec_lo(r_stg_valid, r_stg_addr[1:0]);
  assign w_byp_hi = predec_hi(r_stg_addr[4:2]);
`endif

  // Register array. The zero register has no storage. Its decode term is
  // never consumed, so a write to it drops without extra logic.
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    localparam int HI = i / 4;
    localparam int LO = i % 4;

    if (i == ZERO_REG) begin : g_zero
      assign q[i] = '0;
    end else begin : g_store
      logic [WIDTH-1:0] r_val;
      logic             w_sel;

      assign w_sel = w_wr_hi[HI] & w_wr_lo[LO];

      // Architectural register: async clear, load staged data on select.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_val <= '0;
        end else if (w_sel) begin
          r_val <= r_stg_data;
        end
      end

`ifdef REGFILE_WRITE_BYPASS_EN
      logic w_byp;
      assign w_byp = w_byp_hi[HI] & w_byp_lo[LO];
      assign q[i]  = w_byp ? r_stg_data : r_val;
`else
      assign q[i]  = r_val;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed self-checking bench for regfile_write_bank.
module tb_regfile_write_bank;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk;
  logic                reset_n;
  logic                wr_valid;
  logic                wr_ready;
  logic [4:0]          wr_addr;
  logic [63:0]         wr_data;
  logic                hold;
  logic                stg_valid;
  logic [4:0]          stg_addr;
  logic [63:0]         stg_data;
  logic [31:0][63:0]   q;

  logic [63:0]         exp_q [32];
  int                  n_checks;
  int                  n_fail;

  regfile_write_bank dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .hold      (hold),
    .stg_valid (stg_valid),
    .stg_addr  (stg_addr),
    .stg_data  (stg_data),
    .q         (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++)
      check_eq($sformatf("%s_q%0d", tag, i), q[i], exp_q[i]);
  endtask

  // One rising edge, then return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input logic [4:0] a, input logic [63:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    hold     = 1'b0;
    for (int i = 0; i < 32; i++) exp_q[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_stg_valid", 64'(stg_valid), 64'd0);
    check_eq("rst_wr_ready", 64'(wr_ready), 64'd1);
    check_eq("rst_stg_data", stg_data, 64'd0);
    check_all("rst");
    reset_n = 1'b1;

    // Single write X3
    req(5'd3, 64'h0123_4567_89AB_CDEF);
    step();
    wr_valid = 1'b0;
    check_eq("sw_stg_valid", 64'(stg_valid), 64'd1);
    check_eq("sw_stg_addr", 64'(stg_addr), 64'd3);
    check_eq("sw_stg_data", stg_data, 64'h0123_4567_89AB_CDEF);
    check_eq("sw_q3_early", q[3], BYP ? 64'h0123_4567_89AB_CDEF : 64'd0);
    step();
    exp_q[3] = 64'h0123_4567_89AB_CDEF;
    check_eq("sw_stg_drain", 64'(stg_valid), 64'd0);
    check_all("sw");

    // Same address back to back
    req(5'd9, 64'd1);
    step();
    req(5'd9, 64'd2);
    step();
    wr_valid = 1'b0;
    check_eq("sa_q9_first", q[9], BYP ? 64'd2 : 64'd1);
    step();
    exp_q[9] = 64'd2;
    check_eq("sa_q9_last", q[9], 64'd2);

    // Zero register
    req(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    wr_valid = 1'b0;
    check_eq("zr_stg_valid", 64'(stg_valid), 64'd1);
    check_eq("zr_stg_addr", 64'(stg_addr), 64'd31);
    check_eq("zr_q31_staged", q[31], 64'd0);
    step();
    check_eq("zr_stg_drain", 64'(stg_valid), 64'd0);
    check_all("zr");

    // Hold with a full stage
    req(5'd7, 64'hAA);
    step();
    hold = 1'b1;
    req(5'd8, 64'h88);
    #1;
    check_eq("hd_ready_now", 64'(wr_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq($sformatf("hd_ready_%0d", c), 64'(wr_ready), 64'd0);
      check_eq($sformatf("hd_stg_addr_%0d", c), 64'(stg_addr), 64'd7);
      check_eq($sformatf("hd_stg_data_%0d", c), stg_data, 64'hAA);
      check_eq($sformatf("hd_q7_%0d", c), q[7], BYP ? 64'hAA : 64'd0);
    end
    hold = 1'b0;
    #1;
    check_eq("hd_ready_rel", 64'(wr_ready), 64'd1);
    step();
    wr_valid = 1'b0;
    exp_q[7] = 64'hAA;
    check_eq("hd_q7_commit", q[7], 64'hAA);
    check_eq("hd_stg_addr8", 64'(stg_addr), 64'd8);
    check_eq("hd_stg_data8", stg_data, 64'h88);
    step();
    exp_q[8] = 64'h88;
    check_eq("hd_stg_drain", 64'(stg_valid), 64'd0);
    check_all("hd");

    // Streaming X0..X30
    for (int i = 0; i < 31; i++) begin
      req(5'(i), 64'(i) * 64'h1111);
      #1;
      check_eq($sformatf("st_ready_%0d", i), 64'(wr_ready), 64'd1);
      step();
      exp_q[i] = 64'(i) * 64'h1111;
    end
    wr_valid = 1'b0;
    step();
    check_eq("st_stg_drain", 64'(stg_valid), 64'd0);
    check_all("st");

    // Asynchronous reset between edges with a write staged
    req(5'd5, 64'hDEAD_BEEF_0000_0001);
    step();
    wr_valid = 1'b0;
    check_eq("ar_staged", 64'(stg_valid), 64'd1);
    check_eq("ar_q5_pre", q[5], BYP ? 64'hDEAD_BEEF_0000_0001 : 64'h5555);
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) exp_q[i] = '0;
    check_eq("ar_stg_valid", 64'(stg_valid), 64'd0);
    check_eq("ar_stg_addr", 64'(stg_addr), 64'd0);
    check_eq("ar_stg_data", stg_data, 64'd0);
    check_eq("ar_wr_ready", 64'(wr_ready), 64'd1);
    check_all("ar");
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_eq("ar_no_commit_stg", 64'(stg_valid), 64'd0);
    check_all("ar_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
